exe_stage: RTL and testbench
============================

# exe_stage

Third-to-last pipeline stage of the LoongArch-subset core: receives the decoded ID→EXE bus, holds it in a stage register under the valid/allow_in handshake, computes the ALU result, and issues the data SRAM request for loads and stores. It forwards the result and the WB/MEM control fields to the MEM stage on a packed bus.

## Interface
- No parameters; bus widths are fixed: ID→EXE 113 bits, EXE→MEM 37 bits.
- `clk` in 1: single clock. Everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ID_to_EXE_bus` in 113: fields, MSB first:
  - [112] `rf_w_en`
  - [111] `rf_w_sel`: 1 = RAM, 0 = ALU
  - [110] `ram_byte`: 1 = byte, 0 = word
  - [109] `ram_we`
  - [108] `ram_en`
  - [107:76] `ram_wdata`
  - [75:64] `alu_op`
  - [63:32] `src2`
  - [31:0] `src1`
- `ID_to_EXE_valid` in 1: the ID stage has an instruction for EXE.
- `EXE_allow_in` out 1: EXE accepts the bus this cycle.
- `MEM_allow_in` in 1: the MEM stage accepts this cycle.
- `EXE_to_MEM_valid` out 1: the EXE instruction moves to MEM.
- `EXE_to_MEM_bus` out 37: `{rf_w_en, rf_w_sel, ram_byte, addr_lo[1:0], alu_result[31:0]}`.
- `data_sram_en` out 1: data SRAM request.
- `data_sram_we` out 4: byte write enables.
- `data_sram_addr` out 32: byte address, equal to `alu_result`.
- `data_sram_wdata` out 32: write data, lane-replicated.

## Operation
- **Handshake:**
  - `EXE_ready_go` = 1, since the ALU is single-cycle.
  - `EXE_allow_in = ~EXE_valid | MEM_allow_in`.
  - `EXE_to_MEM_valid = EXE_valid & MEM_allow_in`.
- **Stage register:** when `EXE_allow_in` is high, `EXE_valid <= ID_to_EXE_valid`.
  - The bus register loads `ID_to_EXE_bus` only when `ID_to_EXE_valid & EXE_allow_in`.
  - Otherwise the bus register holds its value.
- **alu_op decoding:** one-hot, bit index to operation:
  - 0 add: `src1+src2` mod 2^32.
  - 1 sub: `src1-src2` mod 2^32.
  - 2 slt: signed `src1<src2`, zero-extended to 32 bits.
  - 3 sltu: unsigned `src1<src2`, zero-extended to 32 bits.
  - 4 and; 5 nor; 6 or; 7 xor.
  - 8 sll: `src1 << src2[4:0]`.
  - 9 srl: logical right shift by `src2[4:0]`.
  - 10 sra: arithmetic right shift by `src2[4:0]`.
  - 11 lui: result = `src2`.
- `alu_op` = 0 gives result 0. Multiple bits set gives the bitwise OR of the selected results; the decoder never produces this case.
- **Data SRAM request:**
  - `data_sram_en = EXE_valid & MEM_allow_in & ram_en`. The request fires exactly once, in the cycle the instruction leaves EXE.
  - `data_sram_we = en ? (ram_we ? (ram_byte ? 4'b0001<<addr[1:0] : 4'hF) : 4'h0) : 4'h0`.
  - `data_sram_wdata = ram_byte ? {4{ram_wdata[7:0]}} : ram_wdata`.
  - `addr_lo = alu_result[1:0]`; MEM uses it for byte-load lane select.
  - Misaligned word accesses are issued unchanged. EXE raises no exception.

## Timing
- **Reset values:**
  - `EXE_valid` = 0 and the bus register is all-zero.
  - `EXE_allow_in` = 1 and `EXE_to_MEM_valid` = 0.
  - `data_sram_en` = 0, `data_sram_we` = 0.
  - `data_sram_addr`, `data_sram_wdata` and `EXE_to_MEM_bus` = 0 (ALU of zero operands).
- **Latency:** one cycle from ID acceptance to EXE presence. Outputs to MEM are combinational from the stage register.
- **SRAM timing:** the SRAM is synchronous. The request in cycle N returns data in cycle N+1 in MEM.
- **MEM stall (`MEM_allow_in` = 0):**
  - The register holds and `EXE_allow_in` = `~EXE_valid`.
  - `data_sram_en` = 0, so no duplicate request is issued.
- **Simultaneous accept and depart:** when `EXE_valid`, `MEM_allow_in` and `ID_to_EXE_valid` are all 1 in the same cycle, the old instruction leaves and the new one loads on the same edge. There is no bubble.
- **Invalid input:** `ID_to_EXE_valid` = 0 while allowed in clears `EXE_valid`, inserting a bubble. The bus register keeps stale data, which is harmless.
- **Reset mid-operation:** `EXE_valid` clears on the next edge, any pending store is dropped, and no SRAM request is issued in the reset cycle (`EXE_valid` = 0 after the edge).

## Test plan
- **Reset, then add:** reset for 2 cycles, then check `EXE_allow_in` = 1, `EXE_to_MEM_valid` = 0, `data_sram_en` = 0.
  - Send add with src1=0x7FFFFFFF, src2=1.
  - Next cycle: `alu_result` = 0x80000000, `EXE_to_MEM_valid` = 1.
- **slt/sltu/sra:** src1=0xFFFFFFFF, src2=1.
  - slt → 1; sltu → 0.
  - sra with src1=0x80000000, src2=0x24 → 0xF8000000 (shift by 4).
- **Byte store:** src1=0x1000, src2=0x3, `ram_wdata`=0x12345678.
  - `data_sram_addr`=0x1003, `we`=4'b1000, `wdata`=0x78787878.
  - `en` = 1 for exactly one cycle.
- **Word load under MEM stall:** hold `MEM_allow_in`=0 for 3 cycles.
  - `data_sram_en` = 0 throughout and `EXE_allow_in` = 0.
  - Release: one cycle of `en`=1 with `we`=0, `addr_lo` correct.
- **Back-to-back stream:** 4 valid instructions with `MEM_allow_in`=1 constantly.
  - 4 consecutive `EXE_to_MEM_valid` pulses, each carrying the result of the matching instruction in order.
- **Reset mid-store:** store held in EXE under stall, then assert reset.
  - After the edge: `EXE_valid` = 0.
  - Release stall: no SRAM write ever occurs.

Source files
------------

// File: rtl/exe_stage.sv
// EXE stage of the LoongArch-subset pipeline: holds the ID->EXE bus under the
// valid/allow_in handshake, runs the single-cycle ALU and issues data SRAM requests.
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic [112:0] ID_to_EXE_bus,
  input  logic         ID_to_EXE_valid,
  output logic         EXE_allow_in,
  input  logic         MEM_allow_in,
  output logic         EXE_to_MEM_valid,
  output logic [36:0]  EXE_to_MEM_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  logic         r_exe_valid;
  logic [112:0] r_bus;

  logic         w_rf_w_en;
  logic         w_rf_w_sel;
  logic         w_ram_byte;
  logic         w_ram_we;
  logic         w_ram_en;
  logic [31:0]  w_ram_wdata;
  logic [11:0]  w_alu_op;
  logic [31:0]  w_src1;
  logic [31:0]  w_src2;
  logic [31:0]  w_alu_result;
  logic [31:0]  w_sra;
  logic         w_exe_ready_go;
  logic         w_depart;

  assign {w_rf_w_en, w_rf_w_sel, w_ram_byte, w_ram_we, w_ram_en,
          w_ram_wdata, w_alu_op, w_src2, w_src1} = r_bus;

  // The ALU always completes in one cycle, so the stage never stalls itself.
  assign w_exe_ready_go   = 1'b1;
  assign EXE_allow_in     = ~r_exe_valid | (w_exe_ready_go & MEM_allow_in);
  assign w_depart         = r_exe_valid & w_exe_ready_go & MEM_allow_in;
  assign EXE_to_MEM_valid = w_depart;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exe_valid <= 1'b0;
      r_bus       <= '0;
    end else if (EXE_allow_in) begin
      r_exe_valid <= ID_to_EXE_valid;
      if (ID_to_EXE_valid) r_bus <= ID_to_EXE_bus;
    end
  end

  assign w_sra = $signed(w_src1) >>> w_src2[4:0];

  // NOTE: the result gets a default before the selective ORs, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_alu_result = '0;
    if (w_alu_op[0])  w_alu_result = w_alu_result | (w_src1 + w_src2);
    if (w_alu_op[1])  w_alu_result = w_alu_result | (w_src1 - w_src2);
    if (w_alu_op[2])  w_alu_result = w_alu_result | {31'b0, $signed(w_src1) < $signed(w_src2)};
    if (w_alu_op[3])  w_alu_result = w_alu_result | {31'b0, w_src1 < w_src2};
    if (w_alu_op[4])  w_alu_result = w_alu_result | (w_src1 & w_src2);
    if (w_alu_op[5])  w_alu_result = w_alu_result | ~(w_src1 | w_src2);
    if (w_alu_op[6])  w_alu_result = w_alu_result | (w_src1 | w_src2);
    if (w_alu_op[7])  w_alu_result = w_alu_result | (w_src1 ^ w_src2);
    if (w_alu_op[8])  w_alu_result = w_alu_result | (w_src1 << w_src2[4:0]);
    if (w_alu_op[9])  w_alu_result = w_alu_result | (w_src1 >> w_src2[4:0]);
    if (w_alu_op[10]) w_alu_result = w_alu_result | w_sra;
    if (w_alu_op[11]) w_alu_result = w_alu_result | w_src2;
  end

  // The request fires only in the departure cycle, so a stalled access is never repeated.
  assign data_sram_en    = w_depart & w_ram_en;
  assign data_sram_we    = (data_sram_en & w_ram_we)
                           ? (w_ram_byte ? (4'b0001 << w_alu_result[1:0]) : 4'hF)
                           : 4'h0;
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = w_ram_byte ? {4{w_ram_wdata[7:0]}} : w_ram_wdata;

  assign EXE_to_MEM_bus  = {w_rf_w_en, w_rf_w_sel, w_ram_byte,
                            w_alu_result[1:0], w_alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage with hand-computed expected values.
module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic [112:0] ID_to_EXE_bus;
  logic         ID_to_EXE_valid;
  logic         EXE_allow_in;
  logic         MEM_allow_in;
  logic         EXE_to_MEM_valid;
  logic [36:0]  EXE_to_MEM_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_checks = 0;
  int n_errors = 0;

  exe_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ID_to_EXE_bus    (ID_to_EXE_bus),
    .ID_to_EXE_valid  (ID_to_EXE_valid),
    .EXE_allow_in     (EXE_allow_in),
    .MEM_allow_in     (MEM_allow_in),
    .EXE_to_MEM_valid (EXE_to_MEM_valid),
    .EXE_to_MEM_bus   (EXE_to_MEM_bus),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [112:0] mk_bus(input logic rf_w_en, input logic rf_w_sel,
                                          input logic ram_byte, input logic ram_we,
                                          input logic ram_en, input logic [31:0] wdata,
                                          input logic [11:0] op, input logic [31:0] src2,
                                          input logic [31:0] src1);
    return {rf_w_en, rf_w_sel, ram_byte, ram_we, ram_en, wdata, op, src2, src1};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [112:0] bus);
    ID_to_EXE_valid = 1'b1;
    ID_to_EXE_bus   = bus;
    tick();
    ID_to_EXE_valid = 1'b0;
    #1;
  endtask

  task automatic alu_case(input string tag, input logic [11:0] op,
                          input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] exp);
    issue(mk_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, op, s2, s1));
    check(tag, {32'h0, EXE_to_MEM_bus[31:0]}, {32'h0, exp});
  endtask

  logic [31:0] stream_s1  [4] = '{32'd10, 32'd20, 32'hF0F0_0000, 32'h0000_0001};
  logic [31:0] stream_s2  [4] = '{32'd5,  32'd7,  32'h0F0F_0000, 32'h0000_0004};
  logic [11:0] stream_op  [4] = '{OP_ADD, OP_SUB, OP_XOR,        OP_SLL};
  logic [31:0] stream_exp [4] = '{32'd15, 32'd13, 32'hFFFF_0000, 32'h0000_0010};

  initial begin
    reset           = 1'b1;
    ID_to_EXE_valid = 1'b0;
    ID_to_EXE_bus   = '0;
    MEM_allow_in    = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;

    check("rst_allow_in", {63'h0, EXE_allow_in}, 64'd1);
    check("rst_to_mem_valid", {63'h0, EXE_to_MEM_valid}, 64'd0);
    check("rst_sram_en", {63'h0, data_sram_en}, 64'd0);
    check("rst_sram_we", {60'h0, data_sram_we}, 64'd0);
    check("rst_bus", {27'h0, EXE_to_MEM_bus}, 64'd0);
    check("rst_addr", {32'h0, data_sram_addr}, 64'd0);
    check("rst_wdata", {32'h0, data_sram_wdata}, 64'd0);

    issue(mk_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, OP_ADD, 32'h1, 32'h7FFF_FFFF));
    check("add_valid", {63'h0, EXE_to_MEM_valid}, 64'd1);
    check("add_bus", {27'h0, EXE_to_MEM_bus}, 64'h10_8000_0000);
    check("add_no_req", {63'h0, data_sram_en}, 64'd0);

    alu_case("slt",  OP_SLT,  32'hFFFF_FFFF, 32'h1,  32'h1);
    alu_case("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1,  32'h0);
    alu_case("sra",  OP_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000);
    alu_case("sub",  OP_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_case("nor",  OP_NOR,  32'hF0F0_0000, 32'h0000_FF00, 32'h0F0F_00FF);
    alu_case("srl",  OP_SRL,  32'h8000_0000, 32'h24, 32'h0800_0000);
    alu_case("sll",  OP_SLL,  32'h0000_0003, 32'h21, 32'h0000_0006);
    alu_case("lui",  OP_LUI,  32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000);
    alu_case("op_zero", 12'h000, 32'h1234_5678, 32'h1, 32'h0);

    // Byte store to lane 3.
    issue(mk_bus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, OP_ADD, 32'h3, 32'h1000));
    check("sb_en", {63'h0, data_sram_en}, 64'd1);
    check("sb_addr", {32'h0, data_sram_addr}, 64'h1003);
    check("sb_we", {60'h0, data_sram_we}, 64'h8);
    check("sb_wdata", {32'h0, data_sram_wdata}, 64'h7878_7878);
    tick();
    check("sb_en_once", {63'h0, data_sram_en}, 64'd0);
    check("sb_we_after", {60'h0, data_sram_we}, 64'd0);

    // Misaligned word load held under a 3-cycle MEM stall while ID offers a newer instruction.
    issue(mk_bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, OP_ADD, 32'h6, 32'h2000));
    MEM_allow_in    = 1'b0;
    ID_to_EXE_valid = 1'b1;
    ID_to_EXE_bus   = mk_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, OP_ADD, 32'h1, 32'h1);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_en_%0d", i), {63'h0, data_sram_en}, 64'd0);
      check($sformatf("stall_allow_%0d", i), {63'h0, EXE_allow_in}, 64'd0);
      check($sformatf("stall_hold_%0d", i), {32'h0, data_sram_addr}, 64'h2006);
      tick();
    end
    MEM_allow_in = 1'b1;
    #1;
    check("lw_en", {63'h0, data_sram_en}, 64'd1);
    check("lw_we", {60'h0, data_sram_we}, 64'd0);
    check("lw_bus", {27'h0, EXE_to_MEM_bus}, 64'h1A_0000_2006);
    check("lw_allow_in", {63'h0, EXE_allow_in}, 64'd1);
    tick();
    ID_to_EXE_valid = 1'b0;
    #1;
    check("swap_valid", {63'h0, EXE_to_MEM_valid}, 64'd1);
    check("swap_result", {32'h0, data_sram_addr}, 64'h2);
    check("swap_no_req", {63'h0, data_sram_en}, 64'd0);
    tick();
    check("bubble_valid", {63'h0, EXE_to_MEM_valid}, 64'd0);

    // Back-to-back stream with MEM always ready.
    for (int i = 0; i < 4; i++) begin
      ID_to_EXE_valid = 1'b1;
      ID_to_EXE_bus   = mk_bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                               stream_op[i], stream_s2[i], stream_s1[i]);
      tick();
      #1;
      check($sformatf("stream_valid_%0d", i), {63'h0, EXE_to_MEM_valid}, 64'd1);
      check($sformatf("stream_res_%0d", i), {32'h0, EXE_to_MEM_bus[31:0]}, {32'h0, stream_exp[i]});
    end
    ID_to_EXE_valid = 1'b0;
    tick();
    check("stream_end", {63'h0, EXE_to_MEM_valid}, 64'd0);

    // Store held under stall, then killed by reset.
    issue(mk_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAABB_CCDD, OP_ADD, 32'h0, 32'h3000));
    MEM_allow_in = 1'b0;
    #1;
    check("rs_held_en", {63'h0, data_sram_en}, 64'd0);
    check("rs_held_allow", {63'h0, EXE_allow_in}, 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rs_valid_cleared", {63'h0, EXE_allow_in}, 64'd1);
    MEM_allow_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rs_no_write_%0d", i), {59'h0, data_sram_en, data_sram_we}, 64'd0);
      check($sformatf("rs_no_valid_%0d", i), {63'h0, EXE_to_MEM_valid}, 64'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
